// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit that writes its result straight into the register bank
// Ports: clk, rst (async, active-low); start/funct3/rs1_data/rs2_data/rd_sel_in request an op, abort kills it;
//        busy stalls the pipeline, done pulses at retirement, reg_w/rd_sel/rd_data drive the bank write port.
module muldiv_unit #(
  parameter int BANK_WIDTH     = 5,
  parameter int REGISTER_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2:0]                funct3,
  input  logic [REGISTER_WIDTH-1:0] rs1_data,
  input  logic [REGISTER_WIDTH-1:0] rs2_data,
  input  logic [BANK_WIDTH-1:0]     rd_sel_in,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      reg_w,
  output logic [BANK_WIDTH-1:0]     rd_sel,
  output logic [REGISTER_WIDTH-1:0] rd_data
);
  localparam int W  = REGISTER_WIDTH;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] p, p_mul, p_div, prod;
  logic [W-1:0] a_q, ub_q, ua, ub, diff, q, r, res;
  logic [W:0] mul_sum, rh;
  logic [2:0] f_q;
  logic neg_q, neg_r_q, dz_q, ov_q, sa, sb, dz, ov, ge, accept;
  assign sa     = (funct3 inside {3'd1, 3'd2, 3'd4, 3'd6}) & rs1_data[W-1];
  assign sb     = (funct3 inside {3'd1, 3'd4, 3'd6}) & rs2_data[W-1];
  assign ua     = sa ? -rs1_data : rs1_data;
  assign ub     = sb ? -rs2_data : rs2_data;
  assign dz     = funct3[2] && rs2_data == '0;
  assign ov     = (funct3 == 3'd4 || funct3 == 3'd6) && rs1_data == {1'b1, {(W-1){1'b0}}} && &rs2_data;
  assign accept = state == IDLE && start && !abort;
  assign busy   = state == CALC || state == FIX;
  assign done   = state == DONE;
  assign reg_w  = done && rd_sel != '0;
  // Multiply step: add the multiplicand into the high half when the low bit is set, then shift right.
  assign mul_sum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, ub_q} : '0);
  assign p_mul   = {mul_sum, p[W-1:1]};
  // Restoring divide step: remainder/quotient pair shifted left, subtract the divisor when it fits.
  assign rh    = p[2*W-1:W-1];
  assign ge    = rh >= {1'b0, ub_q};
  assign diff  = rh[W-1:0] - ub_q;
  assign p_div = {ge ? diff : rh[W-1:0], p[W-2:0], ge};
  assign prod  = neg_q ? -p : p;
  assign q     = neg_q ? -p[W-1:0] : p[W-1:0];
  assign r     = neg_r_q ? -p[2*W-1:W] : p[2*W-1:W];
  assign res   = !f_q[2] ? (f_q == 3'd0 ? prod[W-1:0] : prod[2*W-1:W]) :
                 dz_q    ? (f_q[1] ? a_q : '1) :
                 ov_q    ? (f_q[1] ? '0 : a_q) :
                           (f_q[1] ? r : q);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? ((dz || ov) ? FIX : CALC) : IDLE;
      CALC:    state_n = abort ? IDLE : (cnt == CW'(W-1) ? FIX : CALC);
      FIX:     state_n = abort ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      p       <= '0;
      a_q     <= '0;
      ub_q    <= '0;
      f_q     <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      rd_sel  <= '0;
      rd_data <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt     <= '0;
        p       <= {{W{1'b0}}, ua};
        a_q     <= rs1_data;
        ub_q    <= ub;
        f_q     <= funct3;
        neg_q   <= sa ^ sb;
        neg_r_q <= sa;
        dz_q    <= dz;
        ov_q    <= ov;
        rd_sel  <= rd_sel_in;
      end else if (state == CALC) begin
        p   <= f_q[2] ? p_div : p_mul;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX && !abort) rd_data <= res;
    end
  end
endmodule
